pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Downstream consumer of the immediate shifter (`imm << 2` word-offset output).
- Holds the architectural PC, fetches instructions from instruction memory over a req/ready handshake, and hands each instruction to decode over a valid/ready handshake.
- Computes the next PC from the decode resolution of the delivered instruction: sequential, branch, jump or jump-register.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address (equals pc).
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr holds a valid fetched instruction.
- instr_ready  input  1  decode accepts instr.
- instr  output  32  fetched instruction.
- pc  output  32  address of the current/delivered instruction.
- pc_plus4  output  32  pc + 4, combinational.
- branch_take  input  1  delivered instruction is a taken branch.
- branch_off  input  32  sign-extended branch offset, already shifted left by 2.
- jump_take  input  1  delivered instruction is J/JAL.
- jump_shifted  input  32  26-bit index shifted left by 2 (bits 27:0 used).
- jr_take  input  1  delivered instruction is JR/JALR.
- jr_addr  input  32  register jump target.
- misalign_err  output  1  sticky; JR target not word aligned.

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc = RESET_VECTOR; state = IDLE.
  - imem_req = 0, instr_valid = 0, instr = 0, misalign_err = 0.
  - All inputs are ignored while reset is low, including an in-flight imem_ready.
- States:
  - IDLE: imem_req = 0, instr_valid = 0. Always advances to FETCH on the next edge. This is exactly one cycle after reset release.
  - FETCH: imem_req = 1, imem_addr = pc. When imem_ready = 1, capture instr <= imem_rdata and go to DELIVER. The response may arrive in the same cycle req first rises. Otherwise stay in FETCH with req and addr held stable.
  - DELIVER: instr_valid = 1, imem_req = 0, instr held stable. When instr_ready = 1, the handshake completes: pc <= next_pc and state goes to FETCH. If instr_ready = 0, hold everything.
  - HALT: entered on a misaligned JR. imem_req = 0, instr_valid = 0, misalign_err = 1. Only reset exits HALT.
- next_pc rules, sampled only on the DELIVER handshake cycle. Priority is jr_take > jump_take > branch_take > sequential.
  - jr: jr_addr. If jr_addr[1:0] != 0, the pc is not updated; set misalign_err and go to HALT.
  - jump: {pc_plus4[31:28], jump_shifted[27:0]}.
  - branch: pc_plus4 + branch_off, modulo 2^32 (wrap, no overflow flag).
  - sequential: pc_plus4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect inputs outside the handshake cycle are ignored. Multiple takes asserted together resolve by priority, not as an error.
- Latency:
  - Reset release to first imem_req: 1 cycle.
  - imem_ready to instr_valid: 1 cycle.
  - Handshake to the next imem_req, at the new pc: 1 cycle.
- pc and imem_addr never change while imem_req = 1 or instr_valid = 1.
- Reset asserted mid-FETCH or mid-DELIVER aborts at that edge. No instruction is delivered and no pc update occurs.

Test Plan:
- Reset release, imem_ready tied 1, instr_ready tied 1 -> imem_addr sequence 0, 4, 8, C; one instruction delivered every 2 cycles after the first; instr matches imem_rdata.
- At pc=0x0000_0010: branch_take=1, branch_off=0xFFFF_FFF8 -> next fetch at 0x0000_000C. With branch_off=0x0000_0020 -> next fetch at 0x0000_0034.
- At pc=0x4000_0100: jump_take=1, jump_shifted=0x0000_0040 -> next fetch at 0x4000_0040. Assert branch_take together with jump_take -> jump still wins.
- At handshake: jr_take=1, jr_addr=0x0000_2002 -> misalign_err=1, HALT, no further imem_req, pc unchanged. Then rst_n low for 1 cycle -> pc=RESET_VECTOR, misalign_err=0.
- imem_ready delayed 3 cycles and instr_ready held low 4 cycles -> imem_addr, pc and instr stable throughout; branch_take pulses during the stall are ignored; exactly one pc advance.
- pc=0xFFFF_FFFC sequential -> next pc 0x0000_0000. rst_n low during FETCH while imem_ready=1 -> instr_valid stays 0 and pc=RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: fetches one instruction at a time over a req/ready handshake, delivers it to
// decode over valid/ready, then redirects the PC from the decode resolution of that instruction.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_take,
  input  logic [31:0] branch_off,
  input  logic        jump_take,
  input  logic [31:0] jump_shifted,
  input  logic        jr_take,
  input  logic [31:0] jr_addr,
  output logic        misalign_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFetch   = 2'd1;
  localparam logic [1:0] StDeliver = 2'd2;
  localparam logic [1:0] StHalt    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  // Only the low 28 bits of the jump index participate in the target.
  logic unused_jump_hi;
  assign unused_jump_hi = ^jump_shifted[31:28];

  assign pc_plus4      = pc_q + 32'd4;
  assign jr_misaligned = jr_take && (jr_addr[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (jr_take) begin
      next_pc = jr_addr;
    end else if (jump_take) begin
      next_pc = {pc_plus4[31:28], jump_shifted[27:0]};
    end else if (branch_take) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        if (instr_ready) begin
          if (jr_misaligned) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign imem_req     = (state_q == StFetch);
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == StDeliver);
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer; expected PCs come from an arithmetic model
// of the redirect rules, instruction words from an address-keyed memory pattern.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_take;
  logic [31:0] branch_off;
  logic        jump_take;
  logic [31:0] jump_shifted;
  logic        jr_take;
  logic [31:0] jr_addr;
  logic        misalign_err;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_pc;
  logic [31:0] salt;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .branch_take  (branch_take),
    .branch_off   (branch_off),
    .jump_take    (jump_take),
    .jump_shifted (jump_shifted),
    .jr_take      (jr_take),
    .jr_addr      (jr_addr),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ salt;
  endfunction

  // Reference redirect rules, straight from the architectural definition.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic jr, input logic jp,
                                             input logic br, input logic [31:0] ja,
                                             input logic [31:0] js, input logic [31:0] bo);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jr) return ja;
    if (jp) return (seq & 32'hF000_0000) | (js & 32'h0FFF_FFFF);
    if (br) return seq + bo;
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Memory answers for whatever address is presented; then one clock edge, settle 1ns.
  task automatic cycle();
    imem_rdata = word_at(imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_take = 1'b0;
    jump_take   = 1'b0;
    jr_take     = 1'b0;
  endtask

  task automatic junk_redirects();
    branch_take  = 1'($urandom);
    branch_off   = $urandom;
    jump_take    = 1'($urandom);
    jump_shifted = $urandom;
    jr_take      = 1'($urandom);
    jr_addr      = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready  = 1'($urandom);
    instr_ready = 1'($urandom);
    cycle();
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_pc", pc, RV);
    check("rst_instr", instr, 32'h0);
    check1("rst_err", misalign_err, 1'b0);
    rst_n = 1'b1;
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    exp_pc = RV;
    cycle();
    check1("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, RV);
  endtask

  // One fetch/deliver transaction starting in the fetch state.
  task automatic txn(input int mw, input int dw, input logic jr, input logic jp, input logic br,
                     input logic [31:0] ja, input logic [31:0] js, input logic [31:0] bo);
    logic [31:0] nxt;
    check1("fetch_req", imem_req, 1'b1);
    check("fetch_addr", imem_addr, exp_pc);
    check1("fetch_valid", instr_valid, 1'b0);
    for (int i = 0; i < mw; i++) begin
      imem_ready = 1'b0;
      junk_redirects();
      cycle();
      check1("mwait_req", imem_req, 1'b1);
      check("mwait_addr", imem_addr, exp_pc);
      check("mwait_pc", pc, exp_pc);
    end
    clear_redirects();
    imem_ready = 1'b1;
    cycle();
    imem_ready = 1'b0;
    check1("dlv_valid", instr_valid, 1'b1);
    check1("dlv_req", imem_req, 1'b0);
    check("dlv_instr", instr, word_at(exp_pc));
    check("dlv_pc", pc, exp_pc);
    check("dlv_pc4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < dw; i++) begin
      instr_ready = 1'b0;
      junk_redirects();
      imem_ready = 1'($urandom);
      cycle();
      check1("dwait_valid", instr_valid, 1'b1);
      check("dwait_instr", instr, word_at(exp_pc));
      check("dwait_pc", pc, exp_pc);
    end
    imem_ready   = 1'b0;
    instr_ready  = 1'b1;
    jr_take      = jr;
    jump_take    = jp;
    branch_take  = br;
    jr_addr      = ja;
    jump_shifted = js;
    branch_off   = bo;
    cycle();
    instr_ready = 1'b0;
    clear_redirects();
    nxt = model_next(exp_pc, jr, jp, br, ja, js, bo);
    if (jr && (ja % 4 != 0)) begin
      check1("halt_req", imem_req, 1'b0);
      check1("halt_valid", instr_valid, 1'b0);
      check1("halt_err", misalign_err, 1'b1);
      check("halt_pc", pc, exp_pc);
    end else begin
      exp_pc = nxt;
      check1("next_req", imem_req, 1'b1);
      check("next_addr", imem_addr, exp_pc);
      check1("next_valid", instr_valid, 1'b0);
      check1("next_err", misalign_err, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    salt     = $urandom;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch_off = 32'h0;
    jump_shifted = 32'h0;
    jr_addr = 32'h0;
    clear_redirects();
    exp_pc = RV;
    cycle();
    do_reset();

    // Back-to-back sequential fetches: 0, 4, 8, C, two cycles each.
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_addr, 32'(i * 4));
      txn(0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    end
    check("at_10", pc, 32'h0000_0010);

    txn(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFF8);
    check("br_back", imem_addr, 32'h0000_000C);
    txn(0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    txn(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0020);
    check("br_fwd", imem_addr, 32'h0000_0034);

    // Stalls on both sides with redirect noise: exactly one sequential advance.
    txn(3, 4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("stall_adv", pc, 32'h0000_0038);

    txn(0, 0, 1'b1, 1'b0, 1'b0, 32'h4000_0100, 32'h0, 32'h0);
    check("jr_aligned", pc, 32'h4000_0100);
    txn(0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0040, 32'h0);
    check("jump", imem_addr, 32'h4000_0040);
    txn(0, 0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFABC_DEF0, 32'h0000_0100);
    check("jump_over_br", pc, 32'h4ABC_DEF0);

    txn(1, 1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0000_0100);
    check("jr_prio", pc, 32'hFFFF_FFFC);
    txn(0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("wrap", pc, 32'h0000_0000);
    txn(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_00FC);
    check("br_100", pc, 32'h0000_0100);

    // Reset in fetch with a response arriving at the same edge.
    rst_n = 1'b0;
    imem_ready = 1'b1;
    cycle();
    check1("rfetch_valid", instr_valid, 1'b0);
    check("rfetch_pc", pc, RV);
    check("rfetch_instr", instr, 32'h0);
    rst_n = 1'b1;
    imem_ready = 1'b0;
    exp_pc = RV;
    cycle();
    check1("rfetch_valid2", instr_valid, 1'b0);
    check1("rfetch_req", imem_req, 1'b1);

    // Reset in deliver while the handshake would complete.
    txn(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_01FC);
    imem_ready = 1'b1;
    cycle();
    imem_ready = 1'b0;
    check1("rdlv_pre", instr_valid, 1'b1);
    rst_n = 1'b0;
    instr_ready = 1'b1;
    branch_take = 1'b1;
    branch_off = 32'h0000_1000;
    cycle();
    check1("rdlv_valid", instr_valid, 1'b0);
    check("rdlv_pc", pc, RV);
    rst_n = 1'b1;
    instr_ready = 1'b0;
    clear_redirects();
    exp_pc = RV;
    cycle();
    check("rdlv_addr", imem_addr, RV);

    // Randomized transactions, aligned targets only.
    for (int n = 0; n < 40; n++) begin
      txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom),
          1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom & 32'hFFFF_FFFC);
    end

    // Misaligned register jump halts until reset.
    txn(0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_2002, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      instr_ready = 1'b1;
      cycle();
      check1("halt_hold_req", imem_req, 1'b0);
      check1("halt_hold_err", misalign_err, 1'b1);
      check("halt_hold_pc", pc, exp_pc);
    end
    imem_ready = 1'b0;
    instr_ready = 1'b0;
    do_reset();
    check1("halt_clear_err", misalign_err, 1'b0);
    check("halt_clear_pc", pc, RV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
